gray_add_sched: RTL and testbench

GRAY_ADD_SCHED -- requirements
Module: gray_add_sched

---
 rtl/gray_add_pkg.sv | 13 +
 rtl/gray_rr_arb.sv | 61 ++++++
 rtl/gray_add_sched.sv | 134 +++++++++++++
 tb/tb_gray_add_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_add_pkg.sv
// Shared types and constants for the gray-code add scheduler.
package gray_add_pkg;

  localparam int GRAY_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    ADD  = 2'd2,
    ENC  = 2'd3
  } state_t;

endpackage

// File: rtl/gray_rr_arb.sv
// Two-requester arbiter for gray_add_sched.
// Default build: round-robin, last-served pointer resets to requester 1.
// GRAY_ADD_SCHED_FIXED_PRIO_EN: fixed priority, requester 0 wins, no pointer.
module gray_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

`ifdef GRAY_ADD_SCHED_FIXED_PRIO_EN

  logic unused_rr;
  assign unused_rr = ^{clk, rst, adv};

  // Requester 0 always has precedence
  always_comb begin
    gnt = '0;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

`else

  logic last_q;
  logic last_d;

  // Contention goes to the requester not served last; a lone request always wins
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Pointer follows the granted requester whenever a grant is taken
  always_comb begin
    last_d = last_q;
    if (adv && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  // Last-served pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

`endif

endmodule

// File: rtl/gray_add_sched.sv
// Gray-code adder shared by two requesters: grant, convert, add, encode.
// Arbitration mode is selected by GRAY_ADD_SCHED_FIXED_PRIO_EN (see gray_rr_arb).
module gray_add_sched
  import gray_add_pkg::*;
#(
  parameter int W = GRAY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic [1:0]   done,
  output logic [W:0]   result
);

  state_t       state_q, state_d;
  logic [W-1:0] ga_q, ga_d;
  logic [W-1:0] gb_q, gb_d;
  logic [W-1:0] ba_q, ba_d;
  logic [W-1:0] bb_q, bb_d;
  logic [W:0]   sum_q, sum_d;
  logic [W:0]   result_q, result_d;
  logic [1:0]   done_q, done_d;
  logic         id_q, id_d;
  logic         busy_q, busy_d;

  logic [1:0]   arb_req;
  logic [1:0]   arb_gnt;
  logic         arb_adv;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b        = '0;
    b[W-1]   = g[W-1];
    for (int unsigned i = 1; i < W; i++) begin
      b[W-1-i] = b[W-i] ^ g[W-1-i];
    end
    return b;
  endfunction

  // Requests are only visible to the arbiter while idle and out of reset,
  // so gnt is zero in every other case and the pointer only moves on a real grant
  always_comb begin
    arb_req = ((state_q == IDLE) && !rst) ? req : 2'b00;
    arb_adv = |arb_gnt;
    gnt     = arb_gnt;
  end

  gray_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .adv (arb_adv),
    .gnt (arb_gnt)
  );

  // Next-state and datapath: one pipeline step per state
  always_comb begin
    state_d  = state_q;
    ga_d     = ga_q;
    gb_d     = gb_q;
    ba_d     = ba_q;
    bb_d     = bb_q;
    sum_d    = sum_q;
    result_d = result_q;
    id_d     = id_q;
    done_d   = '0;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          ga_d    = arb_gnt[1] ? a1 : a0;
          gb_d    = arb_gnt[1] ? b1 : b0;
          id_d    = arb_gnt[1];
          state_d = CONV;
        end
      end
      CONV: begin
        ba_d    = gray2bin(ga_q);
        bb_d    = gray2bin(gb_q);
        state_d = ADD;
      end
      ADD: begin
        sum_d   = {1'b0, ba_q} + {1'b0, bb_q};
        state_d = ENC;
      end
      ENC: begin
        result_d = sum_q ^ (sum_q >> 1);
        done_d   = id_q ? 2'b10 : 2'b01;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ga_q     <= '0;
      gb_q     <= '0;
      ba_q     <= '0;
      bb_q     <= '0;
      sum_q    <= '0;
      result_q <= '0;
      done_q   <= '0;
      id_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ga_q     <= ga_d;
      gb_q     <= gb_d;
      ba_q     <= ba_d;
      bb_q     <= bb_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      done_q   <= done_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_gray_add_sched.sv
// Self-checking bench for gray_add_sched with a result scoreboard.
module tb_gray_add_sched;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy;
  logic [1:0]   done;
  logic [W:0]   result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] id;
    logic [W:0] res;
  } exp_t;

  exp_t sb[$];

  gray_add_sched #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Reference: gray decode by prefix XOR, add, gray encode
  function automatic logic [W:0] ref_gray_sum(input logic [W-1:0] ga, input logic [W-1:0] gb);
    logic [W-1:0] xa, xb;
    logic [W:0]   s;
    xa = '0;
    xb = '0;
    for (int i = 0; i < W; i++) begin
      xa = xa ^ (ga >> i);
      xb = xb ^ (gb >> i);
    end
    s = {1'b0, xa} + {1'b0, xb};
    return s ^ (s >> 1);
  endfunction

  task automatic push_exp(input logic [1:0] id, input logic [W:0] res);
    exp_t e;
    e.id  = id;
    e.res = res;
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) begin
      e.id  = 2'bxx;
      e.res = 'x;
    end else begin
      e = sb.pop_front();
    end
  endtask

  // Bounded wait for a done pulse; cycles = -1 on timeout
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        cycles = n;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 2'b11;
    a0 = 4'b0010; b0 = 4'b0110; a1 = 4'b1000; b1 = 4'b1000;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: gnt=%b expected 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: done=%b expected 00", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: result=%b expected 0", result); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL reset_first_contention: gnt=%b expected 01", gnt); end
    req = 2'b00;
  endtask

  task automatic test_single();
    logic [1:0]   rq [3] = '{2'b01, 2'b10, 2'b10};
    logic [W-1:0] ta [3] = '{4'b0010, 4'b1000, 4'b0000};
    logic [W-1:0] tb [3] = '{4'b0110, 4'b1000, 4'b0000};
    logic [W:0]   tr [3] = '{5'b00100, 5'b10001, 5'b00000};
    int           cyc;
    exp_t         e;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rq[k] == 2'b01) begin
        a0 = ta[k]; b0 = tb[k]; a1 = ~ta[k]; b1 = ~tb[k];
      end else begin
        a1 = ta[k]; b1 = tb[k]; a0 = ~ta[k]; b0 = ~tb[k];
      end
      req = rq[k];
      #1;
      checks++; if (gnt !== rq[k]) begin errors++; $display("FAIL single_gnt[%0d]: gnt=%b expected %b", k, gnt, rq[k]); end
      push_exp(rq[k], tr[k]);
      @(posedge clk); #1;
      req = 2'b00;
      wait_done(cyc);
      checks++; if (cyc != 4) begin errors++; $display("FAIL single_latency[%0d]: cycles=%0d expected 4", k, cyc); end
      pop_exp(e);
      checks++; if (done !== e.id) begin errors++; $display("FAIL single_done[%0d]: done=%b expected %b", k, done, e.id); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL single_result[%0d]: result=%b expected %b", k, result, e.res); end
    end
  endtask

  task automatic test_rr();
    logic [1:0] eg;
    exp_t       e;
    apply_reset();
    @(negedge clk);
    a0 = 4'b0010; b0 = 4'b0110; a1 = 4'b1000; b1 = 4'b1000;
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
`ifdef GRAY_ADD_SCHED_FIXED_PRIO_EN
      eg = 2'b01;
`else
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: gnt=%b expected %b", k, gnt, eg); end
      push_exp(eg, eg[1] ? ref_gray_sum(a1, b1) : ref_gray_sum(a0, b0));
      for (int n = 1; n <= 3; n++) begin
        @(negedge clk);
        checks++; if (gnt !== 2'b00 || busy !== 1'b1) begin
          errors++; $display("FAIL rr_busy[%0d.%0d]: gnt=%b busy=%b expected gnt=00 busy=1", k, n, gnt, busy);
        end
      end
      @(negedge clk);
      pop_exp(e);
      checks++; if (done !== e.id) begin errors++; $display("FAIL rr_done[%0d]: done=%b expected %b", k, done, e.id); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL rr_result[%0d]: result=%b expected %b", k, result, e.res); end
    end
    req = 2'b00;
  endtask

  task automatic test_capture();
    int   cyc;
    exp_t e;
    apply_reset();
    @(negedge clk);
    a0 = 4'b0010; b0 = 4'b0110; a1 = 4'b0001; b1 = 4'b0001;
    req = 2'b01;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL capture_gnt: gnt=%b expected 01", gnt); end
    push_exp(2'b01, 5'b00100);
    @(posedge clk); #1;
    a0  = 4'b1111;
    req = 2'b10;
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL capture_busy_gnt: gnt=%b expected 00", gnt); end
    @(negedge clk);
    req = 2'b00;
    wait_done(cyc);
    pop_exp(e);
    checks++; if (done !== e.id) begin errors++; $display("FAIL capture_done: done=%b expected %b", done, e.id); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL capture_result: result=%b expected %b", result, e.res); end
    @(negedge clk);
    checks++; if (done !== 2'b00 || gnt !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL capture_after: done=%b gnt=%b busy=%b expected 00 00 0", done, gnt, busy);
    end
  endtask

  task automatic test_mid_reset();
    int   cyc;
    exp_t e;
    apply_reset();
    @(negedge clk);
    a0 = 4'b0101; b0 = 4'b0011; req = 2'b01;
    @(posedge clk); #1;
    req = 2'b00;
    wait_done(cyc);
    checks++; if (result !== ref_gray_sum(4'b0101, 4'b0011)) begin
      errors++; $display("FAIL midrst_pre_result: result=%b expected %b", result, ref_gray_sum(4'b0101, 4'b0011));
    end
    @(negedge clk);
    a0 = 4'b1100; b0 = 4'b1010; req = 2'b01;
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: busy=%b expected 0", busy); end
    checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result: result=%b expected 0", result); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL midrst_done: done=%b expected 00", done); end
    @(negedge clk);
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL midrst_done_hold: done=%b expected 00", done); end
    rst = 1'b0;
    a0 = 4'b0010; b0 = 4'b0110; req = 2'b01;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_regrant: gnt=%b expected 01", gnt); end
    push_exp(2'b01, ref_gray_sum(a0, b0));
    @(posedge clk); #1;
    req = 2'b00;
    wait_done(cyc);
    pop_exp(e);
    checks++; if (cyc != 4) begin errors++; $display("FAIL midrst_latency: cycles=%0d expected 4", cyc); end
    checks++; if (done !== e.id) begin errors++; $display("FAIL midrst_done_after: done=%b expected %b", done, e.id); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL midrst_result_after: result=%b expected %b", result, e.res); end
  endtask

  task automatic test_sweep();
    int unsigned perm [256];
    int unsigned tmp;
    int unsigned j;
    logic [7:0]  p;
    logic [1:0]  eg;
    int          cyc;
    exp_t        e;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      eg = (r == 0) ? 2'b01 : 2'b10;
      for (int k = 0; k < 256; k++) begin
        p = perm[k][7:0];
        @(negedge clk);
        if (r == 0) begin
          a0 = p[7:4]; b0 = p[3:0]; a1 = W'($urandom); b1 = W'($urandom);
          push_exp(eg, ref_gray_sum(p[7:4], p[3:0]));
        end else begin
          a1 = p[7:4]; b1 = p[3:0]; a0 = W'($urandom); b0 = W'($urandom);
          push_exp(eg, ref_gray_sum(p[7:4], p[3:0]));
        end
        req = eg;
        #1;
        checks++; if (gnt !== eg) begin errors++; $display("FAIL sweep_gnt[r%0d p%02h]: gnt=%b expected %b", r, p, gnt, eg); end
        @(posedge clk); #1;
        req = 2'b00;
        wait_done(cyc);
        pop_exp(e);
        checks++; if (done !== e.id) begin errors++; $display("FAIL sweep_done[r%0d p%02h]: done=%b expected %b", r, p, done, e.id); end
        checks++; if (result !== e.res) begin errors++; $display("FAIL sweep_result[r%0d p%02h]: result=%b expected %b", r, p, result, e.res); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_rr();
    test_capture();
    test_mid_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
